// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: time-shared breathing fade (ramp up, hold, ramp down) run on NCH channels in round-robin order.
// Latency: pwm_out is registered one clock after the cnt/duty/state that produce it; busy/active_ch/cycle_done update with the FSM.
// Backpressure: none; en is a level run request, and dropping it ends the current fade with a ramp down rather than a cut.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          run request, sampled every clock
//   pwm_out     registered PWM outputs, bit i drives channel i
//   active_ch   index of the channel currently fading
//   busy        high whenever the sequencer is not idle
//   cycle_done  one-clock pulse while the last channel sits in its hand-over clock

module pwm_fade_sequencer #(
    parameter int RESOLUTION  = 8,
    parameter int DVSR        = 488,
    parameter int GRAD_THRESH = 250_000,
    parameter int HOLD_STEPS  = 64,
    parameter int NCH         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic [NCH-1:0]          pwm_out,
    output logic [$clog2(NCH)-1:0]  active_ch,
    output logic                    busy,
    output logic                    cycle_done
);

    localparam int CW = $clog2(NCH);
    localparam int PW = (DVSR > 1)        ? $clog2(DVSR)        : 1;
    localparam int GW = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
    localparam int HW = (HOLD_STEPS > 1)  ? $clog2(HOLD_STEPS)  : 1;

    localparam logic [RESOLUTION-1:0] DUTY_MAX  = '1;
    localparam logic [PW-1:0]         PSC_LAST  = PW'(DVSR - 1);
    localparam logic [GW-1:0]         GRAD_LAST = GW'(GRAD_THRESH - 1);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [CW-1:0]         LAST_CH   = CW'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        NEXT
    } state_t;

    state_t                 state;
    logic [PW-1:0]          psc;
    logic [RESOLUTION-1:0]  cnt;
    logic [RESOLUTION-1:0]  duty;
    logic [GW-1:0]          grad;
    logic [HW-1:0]          hold_cnt;
    logic                   tick;
    logic                   fading;
    logic                   step;

    assign tick   = (psc == PSC_LAST);
    assign fading = (state == RAMP_UP) || (state == HOLD) || (state == RAMP_DOWN);
    // The gradient timer only advances while fading, so step cannot fire in IDLE/NEXT.
    assign step   = fading && (grad == GRAD_LAST);

    // Shared prescaler and PWM counter: free-running from reset, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc <= '0;
            cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Fade sequencer. The gradient timer restarts from 0 on every state entry:
    // step-driven transitions get that from the wrap, en-driven ones force it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            duty       <= '0;
            grad       <= '0;
            hold_cnt   <= '0;
            active_ch  <= '0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            grad       <= (fading && !step) ? grad + 1'b1 : '0;

            case (state)
                IDLE: begin
                    duty <= '0;
                    if (en) begin
                        state     <= RAMP_UP;
                        active_ch <= '0;
                        busy      <= 1'b1;
                    end
                end

                RAMP_UP: begin
                    // Losing en takes priority over a coincident step: duty is kept as-is.
                    if (!en) begin
                        state <= RAMP_DOWN;
                        grad  <= '0;
                    end else if (step) begin
                        if (duty == DUTY_MAX) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            duty <= duty + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (!en) begin
                        state <= RAMP_DOWN;
                        grad  <= '0;
                    end else if (step) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= RAMP_DOWN;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end

                RAMP_DOWN: begin
                    // en is ignored here so a fade already heading down always completes.
                    if (step) begin
                        if (duty == '0) begin
                            state      <= NEXT;
                            cycle_done <= (active_ch == LAST_CH);
                        end else begin
                            duty <= duty - 1'b1;
                        end
                    end
                end

                NEXT: begin
                    // Single hand-over clock with duty 0, keeping channel changes glitch-free.
                    if (en) begin
                        state     <= RAMP_UP;
                        active_ch <= (active_ch == LAST_CH) ? '0 : active_ch + 1'b1;
                    end else begin
                        state     <= IDLE;
                        active_ch <= '0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    duty  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Only the active channel can be driven, and only while a fade is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= fading && (active_ch == CW'(i)) && (cnt < duty);
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
module tb_pwm_fade_sequencer;

    localparam int R    = 3;
    localparam int DV   = 2;
    localparam int G    = 4;
    localparam int HS   = 2;
    localparam int NCH  = 3;
    localparam int U    = (1 << R) * G;   // ramp length in clocks
    localparam int H    = HS * G;         // hold length in clocks
    localparam int MAXD = (1 << R) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [NCH-1:0] pwm_out;
    logic [1:0]     active_ch;
    logic           busy;
    logic           cycle_done;

    logic           rst2 = 1'b0;
    logic           en2  = 1'b0;
    logic [NCH-1:0] pwm_out2;
    logic [1:0]     active_ch2;
    logic           busy2;
    logic           cycle_done2;
    bit             done2 = 1'b0;

    pwm_fade_sequencer #(.RESOLUTION(R), .DVSR(DV), .GRAD_THRESH(G), .HOLD_STEPS(HS), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .en(en), .pwm_out(pwm_out),
        .active_ch(active_ch), .busy(busy), .cycle_done(cycle_done)
    );

    pwm_fade_sequencer #(.RESOLUTION(R), .DVSR(1), .GRAD_THRESH(G), .HOLD_STEPS(1), .NCH(NCH)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .pwm_out(pwm_out2),
        .active_ch(active_ch2), .busy(busy2), .cycle_done(cycle_done2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic [1:0]     ch;
        logic           busy;
        logic           cd;
    } exp_t;

    exp_t sb[$];

    // Reference: a channel's fade is a function of clocks elapsed since it began.
    // ph: 0 up, 1 hold, 2 down, 3 hand-over. After a stop, the ramp down starts
    // at elapsed time sk from duty sf and lasts (sf+1) gradient periods.
    function automatic void eval(input int k, input bit stp, input int sk, input int sf,
                                 output int ph, output int d);
        if (!stp) begin
            if (k < U)              begin ph = 0; d = k / G; end
            else if (k < U + H)     begin ph = 1; d = MAXD; end
            else if (k < 2 * U + H) begin ph = 2; d = MAXD - (k - U - H) / G; end
            else                    begin ph = 3; d = 0; end
        end else begin
            if (k < sk + (sf + 1) * G) begin ph = 2; d = sf - (k - sk) / G; end
            else                       begin ph = 3; d = 0; end
        end
    endfunction

    int m_n = 0, m_cnt = 0, m_k = 0, m_sk = 0, m_sf = 0, m_ch = 0;
    bit m_busy = 1'b0, m_stop = 1'b0;

    initial forever begin
        @(negedge rst);
        m_n = 0; m_cnt = 0; m_k = 0; m_sk = 0; m_sf = 0; m_ch = 0;
        m_busy = 1'b0; m_stop = 1'b0;
        sb.delete();
    end

    // Model: one expected output set per clock edge.
    initial forever begin
        exp_t e;
        int pph, pd, nph, nd;
        @(posedge clk);
        e = '0;
        if (rst) begin
            pph = 3; pd = 0;
            if (m_busy) eval(m_k, m_stop, m_sk, m_sf, pph, pd);
            if (m_busy && pph != 3) e.pwm[m_ch] = (m_cnt < pd);
            if (!m_busy) begin
                if (en) begin m_busy = 1'b1; m_ch = 0; m_k = 0; m_stop = 1'b0; end
            end else if (pph == 3) begin
                m_ch = (m_ch + 1) % NCH;
                if (en) begin m_k = 0; m_stop = 1'b0; end
                else begin m_busy = 1'b0; m_ch = 0; end
            end else begin
                m_k++;
                if (!m_stop && pph < 2 && !en) begin m_stop = 1'b1; m_sk = m_k; m_sf = pd; end
            end
            nph = 3; nd = 0;
            if (m_busy) eval(m_k, m_stop, m_sk, m_sf, nph, nd);
            e.busy = m_busy;
            e.ch   = 2'(m_ch);
            e.cd   = m_busy && (nph == 3) && (m_ch == NCH - 1);
            m_n++;
            m_cnt = (m_n / DV) % (1 << R);
        end
        sb.push_back(e);
    end

    // Monitor: compares the DUT against the oldest expectation on each falling edge.
    initial forever begin
        exp_t e, a;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {pwm_out, active_ch, busy, cycle_done};
            check("scoreboard", 64'(a), 64'(e));
            check("one_hot", 64'($countones(pwm_out) <= 1), 64'(1));
        end
    end

    // Main instance: directed scenarios followed by random en activity.
    initial begin
        int exp_ch[4] = '{0, 1, 2, 0};
        int cds, cd_at, zero_hi, hi7, c, g;
        cds = 0; cd_at = 0; zero_hi = 0; hi7 = 0;

        rst = 1'b0; en = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_pwm", 64'(pwm_out), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ch", 64'(active_ch), 64'(0));
        check("reset_cd", 64'(cycle_done), 64'(0));
        rst = 1'b1;
        repeat (200) @(negedge clk);

        // Full sweep; c counts clocks with c = 1 the first clock busy is high.
        en = 1'b1;
        for (int i = 1; i <= 309; i++) begin
            @(negedge clk);
            if (i == 1) check("sweep_busy_rise", 64'(busy), 64'(1));
            if (i == 1 || i == 74 || i == 147 || i == 220)
                check("sweep_active_ch", 64'(active_ch), 64'(exp_ch[(i - 1) / 73]));
            if (i <= 230 && cycle_done) begin cds++; cd_at = i; end
            if (i >= 221 && i <= 224) zero_hi += $countones(pwm_out);
            if (i >= 249 && i <= 264 && pwm_out[0]) hi7++;
        end
        check("sweep_cd_count", 64'(cds), 64'(1));
        check("sweep_cd_time", 64'(cd_at), 64'(219));
        check("duty0_low", 64'(zero_hi), 64'(0));
        check("duty7_high_of_16", 64'(hi7), 64'(14));
        check("stop_on_ch1", 64'(active_ch), 64'(1));

        // Graceful stop from duty 4 on channel 1: stop edge + 20 ramp-down + 1 hand-over.
        en = 1'b0;
        cds = 0; c = 0;
        do begin
            @(negedge clk);
            c++;
            if (cycle_done) cds++;
        end while (busy && c < 300);
        check("stop_len", 64'(c), 64'(22));
        check("stop_ch", 64'(active_ch), 64'(0));
        check("stop_no_cd", 64'(cds), 64'(0));

        // Asynchronous reset during HOLD.
        en = 1'b1;
        repeat (35) @(negedge clk);
        check("hold_busy", 64'(busy), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("async_pwm", 64'(pwm_out), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'(1));
        check("restart_ch", 64'(active_ch), 64'(0));

        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end

        en = 1'b0;
        c = 0;
        while (busy && c < 400) begin @(negedge clk); c++; end
        check("final_idle", 64'(busy), 64'(0));
        repeat (5) @(negedge clk);
        g = 0;
        while (!done2 && g < 5000) begin @(negedge clk); g++; end
        check("second_instance_done", 64'(done2), 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Second instance: DVSR = 1, HOLD_STEPS = 1.
    initial begin
        int c2, hi, cds2;
        hi = 0; cds2 = 0;
        rst2 = 1'b0; en2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        repeat (4) @(negedge clk);
        en2 = 1'b1;
        @(negedge clk);
        check("d1_busy_rise", 64'(busy2), 64'(1));
        c2 = 0;
        while (active_ch2 != 2'd1 && c2 < 500) begin
            @(negedge clk);
            c2++;
            if (cycle_done2) cds2++;
            // Eight clocks with duty 7: exactly one has cnt = 7 when cnt moves every clock.
            if (c2 >= 29 && c2 <= 36 && pwm_out2[0]) hi++;
        end
        check("d1_ch0_len", 64'(c2), 64'(69));
        check("d1_duty7_high_of_8", 64'(hi), 64'(7));
        c2 = 0;
        while (active_ch2 != 2'd2 && c2 < 500) begin
            @(negedge clk);
            c2++;
            if (cycle_done2) cds2++;
        end
        check("d1_ch1_len", 64'(c2), 64'(69));
        check("d1_no_cd", 64'(cds2), 64'(0));
        en2 = 1'b0;
        c2 = 0;
        while (busy2 && c2 < 500) begin @(negedge clk); c2++; end
        check("d1_idle", 64'(busy2), 64'(0));
        done2 = 1'b1;
    end

endmodule
